// File: rtl/chan_pkt_hdr_insert.sv
// -----------------------------------------------------------------------------
// chan_pkt_hdr_insert
//
// Frames each channelizer payload into a self-describing packet:
//   HDR0 = {channel index[15:0], per-channel sequence[15:0]}
//   HDR1 = {expected payload length[15:0], length-error count[15:0]}
//   then the payload samples.
// Keeps a per-channel sequence counter (table indexed by the low CHAN_BITS of
// tuser) and polices payload length: short payloads are closed early, long
// payloads are cut at the expected length and the excess is dropped.
//
// Ports:
//   clk, async_reset_n        single clock, asynchronous active-low reset
//   payload_length            expected beats per payload (0 treated as 1)
//   s_axis_*                  channelizer stream in (tuser = channel index)
//   m_axis_*                  framed stream out (thdr marks header beats)
//   err_cnt                   saturating count of length-errored packets
//   init_done                 sequence table has been cleared after reset
// -----------------------------------------------------------------------------
module chan_pkt_hdr_insert #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 16,
  parameter int CHAN_BITS  = 8,
  parameter int SEQ_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic [15:0]           payload_length,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_thdr,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           err_cnt,
  output logic                  init_done
);

  localparam int Depth = 2 ** CHAN_BITS;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_HDR0, S_HDR1, S_FIRST, S_BODY, S_DROP
  } state_e;

  state_e                state_q, state_d;
  logic [CHAN_BITS-1:0]  init_idx_q, init_idx_d;
  logic                  init_done_q, init_done_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [USER_WIDTH-1:0] hold_user_q, hold_user_d;
  logic                  hold_last_q, hold_last_d;
  logic [15:0]           plen_q, plen_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           err_q, err_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;

  // Output stage
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_hdr_q, out_hdr_d;
  logic                  out_last_q, out_last_d;

  // Sequence table
  logic [SEQ_WIDTH-1:0]  seq_mem [Depth];
  logic                  mem_we;
  logic [CHAN_BITS-1:0]  mem_addr;
  logic [SEQ_WIDTH-1:0]  mem_wdata;

  logic                  out_free;   // output stage can take a new beat this cycle
  logic                  in_ready;
  logic                  in_fire;
  logic                  err_inc;
  logic [15:0]           cnt_next;

  assign out_free = !out_valid_q || m_axis_tready;
  assign in_fire  = s_axis_tvalid && in_ready;
  assign cnt_next = cnt_q + 16'd1;

  // IDLE waits for a fully empty output stage so the previous packet's
  // tlast beat has left before a new packet is captured.
  always_comb begin
    case (state_q)
      S_IDLE:  in_ready = !out_valid_q;
      S_BODY:  in_ready = out_free;
      S_DROP:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    hold_data_d = hold_data_q;
    hold_user_d = hold_user_q;
    hold_last_d = hold_last_q;
    plen_d      = plen_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    out_valid_d = out_valid_q && !m_axis_tready;
    out_data_d  = out_data_q;
    out_hdr_d   = out_hdr_q;
    out_last_d  = out_last_q;
    mem_we      = 1'b0;
    mem_addr    = hold_user_q[CHAN_BITS-1:0];
    mem_wdata   = seq_q + SEQ_WIDTH'(1);
    err_inc     = 1'b0;

    case (state_q)
      S_INIT: begin
        mem_we     = 1'b1;
        mem_addr   = init_idx_q;
        mem_wdata  = '0;
        init_idx_d = init_idx_q + CHAN_BITS'(1);
        if (&init_idx_q) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_IDLE: begin
        if (in_fire) begin
          hold_data_d = s_axis_tdata;
          hold_user_d = s_axis_tuser;
          hold_last_d = s_axis_tlast;
          plen_d      = (payload_length == 16'd0) ? 16'd1 : payload_length;
          seq_d       = seq_mem[s_axis_tuser[CHAN_BITS-1:0]];
          state_d     = S_HDR0;
        end
      end

      S_HDR0: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = DATA_WIDTH'({16'(hold_user_q), 16'(seq_q)});
          out_hdr_d   = 1'b1;
          out_last_d  = 1'b0;
          mem_we      = 1'b1;   // table[chan] = seq + 1, wrapping
          state_d     = S_HDR1;
        end
      end

      S_HDR1: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = DATA_WIDTH'({plen_q, err_q});
          out_hdr_d   = 1'b1;
          out_last_d  = 1'b0;
          state_d     = S_FIRST;
        end
      end

      S_FIRST: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = hold_data_q;
          out_hdr_d   = 1'b0;
          out_last_d  = hold_last_q || (plen_q == 16'd1);
          cnt_d       = 16'd1;
          if (hold_last_q) begin
            err_inc = (plen_q != 16'd1);
            state_d = S_IDLE;
          end else if (plen_q == 16'd1) begin
            err_inc = 1'b1;
            state_d = S_DROP;
          end else begin
            state_d = S_BODY;
          end
        end
      end

      S_BODY: begin
        if (in_fire) begin
          cnt_d       = cnt_next;
          out_valid_d = 1'b1;
          out_data_d  = s_axis_tdata;
          out_hdr_d   = 1'b0;
          out_last_d  = s_axis_tlast || (cnt_next == plen_q);
          // The count never passes plen, so a mismatch on tlast means short.
          if (s_axis_tlast) begin
            err_inc = (cnt_next != plen_q);
            state_d = S_IDLE;
          end else if (cnt_next == plen_q) begin
            err_inc = 1'b1;
            state_d = S_DROP;
          end
        end
      end

      S_DROP: begin
        if (in_fire && s_axis_tlast) state_d = S_IDLE;
      end

      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q     <= S_INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      hold_data_q <= '0;
      hold_user_q <= '0;
      hold_last_q <= 1'b0;
      plen_q      <= 16'd1;
      cnt_q       <= '0;
      err_q       <= '0;
      seq_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hdr_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      hold_data_q <= hold_data_d;
      hold_user_q <= hold_user_d;
      hold_last_q <= hold_last_d;
      plen_q      <= plen_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      seq_q       <= seq_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_hdr_q   <= out_hdr_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: the table has no reset term; the INIT sweep clears it one entry per
  // cycle after every reset, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) seq_mem[mem_addr] <= mem_wdata;
  end

  assign s_axis_tready = in_ready;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_thdr   = out_hdr_q;
  assign m_axis_tlast  = out_last_q;
  assign err_cnt       = err_q;
  assign init_done     = init_done_q;

endmodule
